// File: rtl/btn_debounce_sync.sv
// -----------------------------------------------------------------------------
// btn_debounce_sync
//   Turns one raw, bouncing, asynchronous button/switch input into a clean
//   debounced level plus single-cycle rise/fall pulses. All flops update on the
//   falling edge of clk so the outputs line up with a negedge storage stage
//   downstream.
//
// Ports
//   clk        system clock (negedge active)
//   reset      asynchronous, active-low; clears all state immediately
//   btn_in     raw asynchronous input
//   level_out  debounced level
//   rise_pulse one cycle high in the cycle level_out goes 0->1
//   fall_pulse one cycle high in the cycle level_out goes 1->0
//
// Parameters
//   STABLE_CYCLES  cycles sync2 must hold a new value before level_out follows
//                  (2..2^CNT_W)
//   CNT_W          stability counter width
//
// Build option
//   BTN_ACTIVE_LOW_EN  when defined, btn_in is inverted ahead of the
//                      synchronizer so a low-active button reads as pressed=1.
// -----------------------------------------------------------------------------
module btn_debounce_sync #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} state_t;

  // Terminal count: the wait state sees sync2 stable on the entry edge plus
  // STABLE_CYCLES-1 further edges before committing.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             btn_raw;
  logic             sync1_q, sync2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

`ifdef BTN_ACTIVE_LOW_EN
  // Reset value 0 of the sync chain is then the logical "released" value.
  assign btn_raw = ~btn_in;
`else
  assign btn_raw = btn_in;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LO: begin
        cnt_d = '0;
        if (sync2_q) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (!sync2_q) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HI: begin
        cnt_d = '0;
        if (!sync2_q) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (sync2_q) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_btn_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_sync
//   Bench for btn_debounce_sync with STABLE_CYCLES=4. A table of directed
//   vectors (reset, clean press, bounce, release, reset mid-wait) is applied
//   first, then a randomized phase is checked against a streak-count model:
//   level flips once the twice-delayed input has disagreed with it on
//   STABLE_CYCLES+1 consecutive falling edges. Stimulus is written in terms of
//   "pressed"; the physical pin is inverted when BTN_ACTIVE_LOW_EN is defined.
// -----------------------------------------------------------------------------
module tb_btn_debounce_sync;
  localparam int STABLE = 4;
`ifdef BTN_ACTIVE_LOW_EN
  localparam logic ACT_LO = 1'b1;
`else
  localparam logic ACT_LO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_in = ACT_LO;
  logic level_out, rise_pulse, fall_pulse;

  btn_debounce_sync #(.STABLE_CYCLES(STABLE), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic press;
    logic lvl;
    logic r;
    logic f;
  } vec_t;
  vec_t vt[$];

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic m_s1, m_s2, m_lvl, m_r, m_f;
  int   m_run;

  task automatic add(input int n, input logic rst, input logic press,
                     input logic lvl, input logic r, input logic f);
    vec_t v;
    v.rst = rst; v.press = press; v.lvl = lvl; v.r = r; v.f = f;
    repeat (n) vt.push_back(v);
  endtask

  task automatic model(input logic rst, input logic press);
    if (!rst) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_r = 0; m_f = 0; m_run = 0;
    end else begin
      m_r = 0; m_f = 0;
      if (m_s2 != m_lvl) begin
        m_run++;
        if (m_run == STABLE + 1) begin
          m_lvl = ~m_lvl;
          m_run = 0;
          if (m_lvl) m_r = 1; else m_f = 1;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = press;
    end
  endtask

  // Drive away from the active (falling) edge, sample 1 time unit after it.
  task automatic step(input logic rst, input logic press);
    @(posedge clk);
    reset  = rst;
    btn_in = press ^ ACT_LO;
    @(negedge clk);
    #1;
    model(rst, press);
  endtask

  task automatic check(input string name, input int idx,
                       input logic lvl, input logic r, input logic f);
    n_vec++;
    if (level_out !== lvl || rise_pulse !== r || fall_pulse !== f) begin
      n_err++;
      $display("FAIL %s[%0d]: got lvl/rise/fall=%b%b%b want %b%b%b",
               name, idx, level_out, rise_pulse, fall_pulse, lvl, r, f);
    end
  endtask

  initial begin
    model(1'b0, 1'b0);

    // 1: reset held with button pressed
    add(5, 0, 1, 0, 0, 0);
    add(3, 1, 0, 0, 0, 0);
    // 2: clean press, level on 7th edge
    add(6, 1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 1, 0);
    add(2, 1, 1, 1, 0, 0);
    // 4: release
    add(6, 1, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1);
    add(2, 1, 0, 0, 0, 0);
    // 3: bounce 1,0,1,1,0 then 1 held; rise 7 edges after final 0->1
    add(1, 1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    add(2, 1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    add(6, 1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 1, 0);
    add(2, 1, 1, 1, 0, 0);
    add(6, 1, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1);
    add(2, 1, 0, 0, 0, 0);
    // 5: reset on 5th edge of a press, released 2 cycles later, still pressed
    add(4, 1, 1, 0, 0, 0);
    add(2, 0, 1, 0, 0, 0);
    add(6, 1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 1, 0);
    add(2, 1, 1, 1, 0, 0);
    add(6, 1, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1);
    add(2, 1, 0, 0, 0, 0);

    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].press);
      check("vec", i, vt[i].lvl, vt[i].r, vt[i].f);
    end

    // randomized phase against the reference model
    begin
      logic rst, press;
      int   hold, k;
      k = 0;
      for (int s = 0; s < 400; s++) begin
        rst   = ($urandom_range(0, 59) != 0);
        press = $urandom_range(0, 1);
        hold  = rst ? $urandom_range(1, 9) : $urandom_range(1, 2);
        repeat (hold) begin
          step(rst, press);
          check("rand", k, m_lvl, m_r, m_f);
          if (rise_pulse === 1'b1 && fall_pulse === 1'b1) begin
            n_err++;
            $display("FAIL both_pulses[%0d]: got rise=1 fall=1 want not both", k);
          end
          k++;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/btn_debounce_sync.md
Name: btn_debounce_sync

Overview:
- Conditions one raw, asynchronous push-button/switch input into a clean, glitch-free level and single-cycle edge pulses.
- Sits directly upstream of the lab's storage stage: level_out drives a flip-flop's D input, or rise_pulse serves as its enable/clock-qualifier.
- All state updates on the falling edge of clk, matching the downstream storage stage, so no half-cycle hazards exist at the boundary.

Parameters:
- STABLE_CYCLES, 50000: consecutive cycles the synchronized input must hold a new value before level_out follows it. Legal range 2..2^CNT_W.
- CNT_W, 16: width of the stability counter.

Ports:
- clk  input  1  system clock; all flops update on negedge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- btn_in  input  1  raw, asynchronous, bouncing input.
- level_out  output  1  debounced level.
- rise_pulse  output  1  one-cycle high when level_out goes 0->1.
- fall_pulse  output  1  one-cycle high when level_out goes 1->0.

Behaviour:
- Reset (reset=0, asynchronous): sync1=sync2=0, state=IDLE_LO, cnt=0, level_out=0, rise_pulse=0, fall_pulse=0. Outputs are held while reset is low.
- Synchronizer: 2-flop chain btn_in->sync1->sync2. Only sync2 is seen by the FSM; btn_in never reaches logic directly.
- FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
  - IDLE_LO: if sync2=1 -> WAIT_HI, cnt<=0.
  - WAIT_HI: if sync2=0 -> IDLE_LO, cnt<=0, no pulse. Else if cnt==STABLE_CYCLES-1 -> IDLE_HI, level_out<=1, rise_pulse<=1. Else cnt<=cnt+1.
  - IDLE_HI: if sync2=0 -> WAIT_LO, cnt<=0.
  - WAIT_LO: mirror of WAIT_HI; on reaching the count -> IDLE_LO, level_out<=0, fall_pulse<=1.
- Pulses are registered, exactly one cycle wide, and coincide with the cycle in which level_out changes.
- rise_pulse and fall_pulse are never high simultaneously.
- Latency: level_out changes on the (STABLE_CYCLES+3)th falling edge, counting the edge that first samples the new btn_in value into sync1.
- Glitch rejection: any reversion of sync2 during WAIT_* aborts the wait, restarts the count from 0 on the next attempt, and produces no output change.
- cnt is held at 0 in IDLE_* states, so it cannot wrap.
- Reset asserted mid-WAIT: the pending transition is discarded. After release the block starts from IDLE_LO even if btn_in is high, and then debounces up normally, taking the full latency.
- Reset deassertion is not synchronized internally. The system must release reset away from the clk falling edge.

Optional Feature:
- Macro: BTN_ACTIVE_LOW_EN.
- Defined: btn_in is inverted before sync1, so a pressed low-active button (btn_in=0) yields level_out=1. The reset value of sync1/sync2 remains 0, which is the logical "released" value.
- Undefined: btn_in is used non-inverted (high = pressed).
- No other behaviour differs.

Test Plan:
All scenarios use STABLE_CYCLES=4 and count clk falling edges.
1. Reset check: hold reset=0 with btn_in=1 for 5 cycles -> level_out=0, rise_pulse=0, fall_pulse=0 throughout.
2. Clean press: after reset release, btn_in 0->1 and held -> level_out rises on the 7th falling edge after the first sampling edge; rise_pulse=1 for exactly that one cycle.
3. Bounce: btn_in pattern 1,0,1,1,0 (one cycle each), then 1 held -> no pulse during the bounce; level_out rises exactly 7 edges after the final 0->1; exactly one rise_pulse.
4. Release: from level_out=1, btn_in 1->0 held -> fall_pulse is a single cycle on the 7th edge and level_out=0 from that edge.
5. Reset mid-wait: press, then reset=0 on the 5th edge (still in WAIT_HI), released 2 cycles later with btn_in still 1 -> no rise_pulse before reset; level_out rises 7 edges after release; no stray pulse.
6. Active-low build: compile with BTN_ACTIVE_LOW_EN and drive btn_in 1->0 held -> level_out=1 and rise_pulse after 7 edges; btn_in back to 1 -> fall_pulse after 7 edges.
